// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller.
// The lookup is combinational and a hit returns data in the same cycle.
// A miss refills one whole line from backing memory, using an
// IDLE -> REQ -> FILL -> DONE sequence. There is no write-back.
module icache_ctrl #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] iCacheReadAddr,
    output logic [31:0] iCacheReadData,
    output logic        iCacheStall,
    input  logic        flush,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memReady,
    input  logic [31:0] memRdata,
    input  logic        memRvalid
);
    localparam int OW = $clog2(WORDS);
    localparam int IW = $clog2(LINES);
    localparam int LW = 30 - OW;
    localparam int TW = LW - IW;

    localparam logic [OW-1:0] LAST_WORD = OW'(WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [LW-1:0]    line_q, line_d;
    logic [OW-1:0]    cnt_q, cnt_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic             fpend_q, fpend_d;

    logic [TW-1:0]    tag_q  [LINES];
    logic [31:0]      data_q [LINES][WORDS];
    logic             tag_we;
    logic             data_we;

    logic [OW-1:0]    addr_off;
    logic [IW-1:0]    addr_idx;
    logic [TW-1:0]    addr_tag;
    logic [IW-1:0]    fill_idx;
    logic [TW-1:0]    fill_tag;
    logic             hit;
    logic             unused_addr_lsbs;

    assign addr_off = iCacheReadAddr[OW+1:2];
    assign addr_idx = iCacheReadAddr[OW+IW+1:OW+2];
    assign addr_tag = iCacheReadAddr[31:OW+IW+2];
    assign fill_idx = line_q[IW-1:0];
    assign fill_tag = line_q[LW-1:IW];

    // The byte offset within a word has no effect on an instruction fetch.
    assign unused_addr_lsbs = ^iCacheReadAddr[1:0];

    assign hit            = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    assign iCacheReadData = data_q[addr_idx][addr_off];
    assign iCacheStall    = (state_q != S_IDLE) || !hit;
    assign memReq         = (state_q == S_REQ);
    assign memAddr        = {line_q, {(OW + 2){1'b0}}};

    // Next-state logic for the refill FSM, the valid bits and the pending-flush flag.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        fpend_d = fpend_q;
        tag_we  = 1'b0;
        data_we = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!hit) begin
                    // Evict the victim now, so that a partial refill can never look valid.
                    line_d            = iCacheReadAddr[31:OW+2];
                    valid_d[addr_idx] = 1'b0;
                    state_d           = S_REQ;
                end
            end
            S_REQ: begin
                if (memReady) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (memRvalid) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                tag_we = 1'b1;
                if (!fpend_q) begin
                    valid_d[fill_idx] = 1'b1;
                end
                fpend_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        // A flush wins over everything. If it arrives mid-refill, the line being
        // fetched must stay invalid, so the DONE state has to remember it.
        if (flush) begin
            valid_d = '0;
            if ((state_q == S_REQ) || (state_q == S_FILL)) begin
                fpend_d = 1'b1;
            end
        end
    end

    // Control state, with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            line_q  <= '0;
            cnt_q   <= '0;
            valid_q <= '0;
            fpend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            fpend_q <= fpend_d;
        end
    end

    // Tag and data arrays. These are not reset, because the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[fill_idx][cnt_q] <= memRdata;
        end
        if (tag_we) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: refill, eviction, backpressure, flush and reset.
`timescale 1ns/1ps
module tb_icache_ctrl;
    localparam int LINES = 16;
    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] iCacheReadAddr = 32'h0;
    logic [31:0] iCacheReadData;
    logic        iCacheStall;
    logic        flush = 1'b0;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memReady = 1'b0;
    logic [31:0] memRdata = 32'h0;
    logic        memRvalid = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    icache_ctrl #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .iCacheReadAddr(iCacheReadAddr), .iCacheReadData(iCacheReadData),
        .iCacheStall(iCacheStall), .flush(flush),
        .memReq(memReq), .memAddr(memAddr), .memReady(memReady),
        .memRdata(memRdata), .memRvalid(memRvalid)
    );

    // Backing memory contents. Line 0x40 holds 0xA0..0xA3. Every other word is
    // {addr[15:0]^0x5A5A, addr[15:0]}.
    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a[31:4] == 28'h4) return 32'hA0 + {30'd0, a[3:2]};
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drives one complete refill for the current address. It returns one cycle
    // after DONE, with the controller back in IDLE.
    task automatic refill(input int rdly, input bit gaps);
        logic [31:0] la;
        int n;
        int g;
        la = iCacheReadAddr & 32'hFFFF_FFF0;
        g = 0;
        while (!memReq && g < 8) begin cyc(); g++; end
        repeat (rdly) cyc();
        memReady = 1'b1; cyc(); memReady = 1'b0;
        n = 0; g = 0;
        while (n < WORDS && g < 64) begin
            if (gaps && g[0]) begin
                memRvalid = 1'b0; memRdata = 32'hDEADBEEF;
            end else begin
                memRvalid = 1'b1; memRdata = memval(la + 32'(n * 4)); n++;
            end
            g++;
            cyc();
        end
        memRvalid = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1; #3; rst = 1'b0;
        iCacheReadAddr = 32'h40; #1;
        checks++; if (iCacheStall !== 1'b1) begin failures++; $display("FAIL reset_stall got=%b want=1", iCacheStall); end
        checks++; if (memReq !== 1'b0) begin failures++; $display("FAIL reset_memreq got=%b want=0", memReq); end
        checks++; if (memAddr !== 32'h0) begin failures++; $display("FAIL reset_memaddr got=%h want=0", memAddr); end
        cyc(); cyc();
        checks++; if (memReq !== 1'b0) begin failures++; $display("FAIL reset_hold_memreq got=%b want=0", memReq); end
        rst = 1'b1; #1;
        checks++; if (memReq !== 1'b0) begin failures++; $display("FAIL release_memreq got=%b want=0", memReq); end
    endtask

    task automatic test_basic_fill();
        iCacheReadAddr = 32'h40; #1;
        checks++; if (iCacheStall !== 1'b1) begin failures++; $display("FAIL miss_stall got=%b want=1", iCacheStall); end
        cyc();
        checks++; if (memReq !== 1'b1) begin failures++; $display("FAIL req_memreq got=%b want=1", memReq); end
        checks++; if (memAddr !== 32'h40) begin failures++; $display("FAIL req_memaddr got=%h want=00000040", memAddr); end
        memReady = 1'b1; cyc(); memReady = 1'b0;
        checks++; if (memReq !== 1'b0) begin failures++; $display("FAIL fill_memreq got=%b want=0", memReq); end
        for (int i = 0; i < 4; i++) begin
            memRvalid = 1'b1; memRdata = 32'hA0 + 32'(i); #1;
            checks++; if (iCacheStall !== 1'b1) begin failures++; $display("FAIL fill_stall word=%0d got=%b want=1", i, iCacheStall); end
            cyc();
        end
        memRvalid = 1'b0;
        checks++; if (iCacheStall !== 1'b1) begin failures++; $display("FAIL done_stall got=%b want=1", iCacheStall); end
        cyc();
        checks++; if (iCacheStall !== 1'b0) begin failures++; $display("FAIL hit40_stall got=%b want=0", iCacheStall); end
        checks++; if (iCacheReadData !== 32'hA0) begin failures++; $display("FAIL hit40_data got=%h want=000000a0", iCacheReadData); end
        iCacheReadAddr = 32'h4C; #1;
        checks++; if (iCacheStall !== 1'b0) begin failures++; $display("FAIL hit4c_stall got=%b want=0", iCacheStall); end
        checks++; if (iCacheReadData !== 32'hA3) begin failures++; $display("FAIL hit4c_data got=%h want=000000a3", iCacheReadData); end
        iCacheReadAddr = 32'h46; #1;
        checks++; if (iCacheReadData !== 32'hA1) begin failures++; $display("FAIL hit46_data got=%h want=000000a1", iCacheReadData); end
        cyc();
    endtask

    task automatic test_evict();
        iCacheReadAddr = 32'h140; #1;
        checks++; if (iCacheStall !== 1'b1) begin failures++; $display("FAIL evict_stall got=%b want=1", iCacheStall); end
        cyc();
        checks++; if (memAddr !== 32'h140) begin failures++; $display("FAIL evict_memaddr got=%h want=00000140", memAddr); end
        refill(0, 1'b0);
        checks++; if (iCacheReadData !== 32'h5B1A0140) begin failures++; $display("FAIL evict_data140 got=%h want=5b1a0140", iCacheReadData); end
        iCacheReadAddr = 32'h144; #1;
        checks++; if (iCacheReadData !== 32'h5B1E0144) begin failures++; $display("FAIL evict_data144 got=%h want=5b1e0144", iCacheReadData); end
        iCacheReadAddr = 32'h40; #1;
        checks++; if (iCacheStall !== 1'b1) begin failures++; $display("FAIL remiss40_stall got=%b want=1", iCacheStall); end
        refill(0, 1'b0);
        checks++; if (iCacheReadData !== 32'hA0 || iCacheStall !== 1'b0) begin failures++; $display("FAIL refill40 got=%h/%b want=000000a0/0", iCacheReadData, iCacheStall); end
    endtask

    task automatic test_backpressure();
        logic [31:0] expw [4];
        bit pat [7];
        int n;
        expw = '{32'h585A0200, 32'h585E0204, 32'h58520208, 32'h5856020C};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        iCacheReadAddr = 32'h200; #1;
        cyc();
        memRvalid = 1'b1; memRdata = 32'hBAD0BAD0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (memReq !== 1'b1 || memAddr !== 32'h200) begin failures++; $display("FAIL hold_req cyc=%0d got=%b/%h want=1/00000200", i, memReq, memAddr); end
            cyc();
        end
        memRvalid = 1'b0; memReady = 1'b1; cyc(); memReady = 1'b0;
        n = 0;
        for (int k = 0; k < 7; k++) begin
            if (pat[k]) begin memRvalid = 1'b1; memRdata = memval(32'h200 + 32'(n * 4)); n++; end
            else begin memRvalid = 1'b0; memRdata = 32'hDEADBEEF; end
            cyc();
        end
        memRvalid = 1'b0;
        cyc();
        for (int w = 0; w < 4; w++) begin
            iCacheReadAddr = 32'h200 + 32'(w * 4); #1;
            checks++; if (iCacheStall !== 1'b0 || iCacheReadData !== expw[w]) begin failures++; $display("FAIL gap_word%0d got=%h/%b want=%h/0", w, iCacheReadData, iCacheStall, expw[w]); end
        end
        cyc();
    endtask

    task automatic test_flush_idle();
        iCacheReadAddr = 32'h40; flush = 1'b1; #1;
        checks++; if (iCacheStall !== 1'b0 || iCacheReadData !== 32'hA0) begin failures++; $display("FAIL flush_same_cycle got=%h/%b want=000000a0/0", iCacheReadData, iCacheStall); end
        cyc(); flush = 1'b0; #1;
        checks++; if (iCacheStall !== 1'b1) begin failures++; $display("FAIL flush_invalid got=%b want=1", iCacheStall); end
        refill(0, 1'b0);
        checks++; if (iCacheStall !== 1'b0 || iCacheReadData !== 32'hA0) begin failures++; $display("FAIL flush_refill got=%h/%b want=000000a0/0", iCacheReadData, iCacheStall); end
    endtask

    task automatic test_flush_fill();
        iCacheReadAddr = 32'h80; #1;
        cyc();
        memReady = 1'b1; cyc(); memReady = 1'b0;
        for (int n = 0; n < 4; n++) begin
            memRvalid = 1'b1; memRdata = memval(32'h80 + 32'(n * 4)); flush = (n == 1);
            cyc();
        end
        memRvalid = 1'b0; flush = 1'b0;
        checks++; if (iCacheStall !== 1'b1) begin failures++; $display("FAIL ffill_done_stall got=%b want=1", iCacheStall); end
        cyc();
        checks++; if (iCacheStall !== 1'b1 || memReq !== 1'b0) begin failures++; $display("FAIL ffill_remiss got=%b/%b want=1/0", iCacheStall, memReq); end
        cyc();
        checks++; if (memReq !== 1'b1 || memAddr !== 32'h80) begin failures++; $display("FAIL ffill_newreq got=%b/%h want=1/00000080", memReq, memAddr); end
        refill(0, 1'b0);
        checks++; if (iCacheStall !== 1'b0 || iCacheReadData !== 32'h5ADA0080) begin failures++; $display("FAIL ffill_data got=%h/%b want=5ada0080/0", iCacheReadData, iCacheStall); end
    endtask

    task automatic test_reset_fill();
        iCacheReadAddr = 32'hC0; #1;
        cyc();
        memReady = 1'b1; cyc(); memReady = 1'b0;
        for (int n = 0; n < 2; n++) begin
            memRvalid = 1'b1; memRdata = memval(32'hC0 + 32'(n * 4)); cyc();
        end
        memRvalid = 1'b0;
        rst = 1'b0; #1;
        checks++; if (memReq !== 1'b0 || memAddr !== 32'h0) begin failures++; $display("FAIL rfill_abort got=%b/%h want=0/00000000", memReq, memAddr); end
        iCacheReadAddr = 32'h80; #1;
        checks++; if (iCacheStall !== 1'b1) begin failures++; $display("FAIL rfill_invalid got=%b want=1", iCacheStall); end
        cyc();
        rst = 1'b1; memRvalid = 1'b1; memRdata = 32'hBAADF00D;
        cyc();
        checks++; if (memReq !== 1'b1 || memAddr !== 32'h80) begin failures++; $display("FAIL rfill_req got=%b/%h want=1/00000080", memReq, memAddr); end
        cyc();
        memRvalid = 1'b0;
        refill(0, 1'b0);
        checks++; if (iCacheStall !== 1'b0 || iCacheReadData !== 32'h5ADA0080) begin failures++; $display("FAIL rfill_data80 got=%h/%b want=5ada0080/0", iCacheReadData, iCacheStall); end
        iCacheReadAddr = 32'h84; #1;
        checks++; if (iCacheReadData !== 32'h5ADE0084) begin failures++; $display("FAIL rfill_data84 got=%h want=5ade0084", iCacheReadData); end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            a = 32'($urandom_range(0, 255)) << 2;
            iCacheReadAddr = a; #1;
            if (iCacheStall) refill(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            checks++; if (iCacheStall !== 1'b0 || iCacheReadData !== memval(a)) begin failures++; $display("FAIL stream addr=%h got=%h/%b want=%h/0", a, iCacheReadData, iCacheStall, memval(a)); end
            checks++; if (memReq !== 1'b0) begin failures++; $display("FAIL stream_memreq addr=%h got=%b want=0", a, memReq); end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_evict();
        test_backpressure();
        test_flush_idle();
        test_flush_fill();
        test_reset_fill();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
